// File: rtl/ahb_lite_subsys.sv
// AHB-Lite slave subsystem: word RAM with wait states, GPIO set/clear/toggle
// port, free-running timer and a two-cycle ERROR response for unmapped addresses.
module ahb_lite_subsys #(
    parameter int                RAM_DEPTH  = 64,
    parameter int                RAM_WAIT   = 0,
    parameter int                GPIO_W     = 3,
    parameter logic [GPIO_W-1:0] GPIO_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADY,
    output logic              HRESP,
    output logic [GPIO_W-1:0] gpio_out
);

    localparam int         AW        = $clog2(RAM_DEPTH);
    localparam int         IW        = (AW > 3) ? AW : 3;
    localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT);

    localparam logic [2:0] SEL_DATA  = 3'd0;
    localparam logic [2:0] SEL_SET   = 3'd1;
    localparam logic [2:0] SEL_CLR   = 3'd2;
    localparam logic [2:0] SEL_TGL   = 3'd3;
    localparam logic [2:0] SEL_TIMER = 3'd4;

    typedef enum logic [2:0] {
        D_IDLE,
        D_RAM,
        D_REG,
        D_ERR1,
        D_ERR2
    } dstate_e;

    dstate_e           state_q, state_d;
    logic [IW-1:0]     addr_q, addr_d;
    logic              write_q, write_d;
    logic [3:0]        wait_q, wait_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [31:0]       timer_q, timer_d;
    logic [31:0]       mem_q [RAM_DEPTH];

    logic          accept;
    logic          ram_hit;
    logic          reg_hit;
    logic          ram_done;
    logic          reg_wr;
    logic          ram_we;
    logic [2:0]    sel;
    logic [AW-1:0] ram_idx;
    logic          unused;

    // Byte lane bits and the SEQ/NONSEQ distinction carry no meaning here.
    assign unused   = ^{HADDR[1:0], HTRANS[0]};

    assign accept   = HREADY & HTRANS[1];
    assign ram_hit  = (HADDR[31:AW+2] == '0);
    assign reg_hit  = (HADDR[31:5] == 27'h100_0000) && (HADDR[4:2] <= SEL_TIMER);
    assign sel      = addr_q[2:0];
    assign ram_idx  = addr_q[AW-1:0];
    assign ram_done = (state_q == D_RAM) && (wait_q == 4'd0);
    assign reg_wr   = (state_q == D_REG) && write_q;
    assign ram_we   = ram_done && write_q;
    assign gpio_out = gpio_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= D_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (HREADY) begin
            if (!accept) begin
                state_d = D_IDLE;
            end else if (ram_hit) begin
                state_d = D_RAM;
            end else if (reg_hit) begin
                state_d = D_REG;
            end else begin
                state_d = D_ERR1;
            end
        end else if (state_q == D_ERR1) begin
            state_d = D_ERR2;
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        unique case (state_q)
            D_IDLE: HREADY = 1'b1;
            D_RAM:  HREADY = (wait_q == 4'd0);
            D_REG:  HREADY = 1'b1;
            D_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            D_ERR2: HRESP = 1'b1;
            default: HREADY = 1'b1;
        endcase
    end

    always_comb begin
        HRDATA = '0;
        if (ram_done && !write_q) begin
            HRDATA = mem_q[ram_idx];
        end else if ((state_q == D_REG) && !write_q) begin
            case (sel)
                SEL_DATA:  HRDATA = 32'(gpio_q);
                SEL_TIMER: HRDATA = timer_q;
                default:   HRDATA = '0;
            endcase
        end
    end

    always_comb begin
        addr_d  = accept ? HADDR[IW+1:2] : addr_q;
        write_d = accept ? HWRITE : write_q;

        // A RAM completion and a new RAM accept never overlap with a nonzero count.
        wait_d = wait_q;
        if (accept && ram_hit) begin
            wait_d = WAIT_INIT;
        end else if ((state_q == D_RAM) && (wait_q != 4'd0)) begin
            wait_d = wait_q - 4'd1;
        end

        gpio_d = gpio_q;
        if (reg_wr) begin
            case (sel)
                SEL_DATA: gpio_d = HWDATA[GPIO_W-1:0];
                SEL_SET:  gpio_d = gpio_q | HWDATA[GPIO_W-1:0];
                SEL_CLR:  gpio_d = gpio_q & ~HWDATA[GPIO_W-1:0];
                SEL_TGL:  gpio_d = gpio_q ^ HWDATA[GPIO_W-1:0];
                default:  gpio_d = gpio_q;
            endcase
        end

        timer_d = timer_q + 32'd1;
        if (reg_wr && (sel == SEL_TIMER)) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wait_q  <= 4'd0;
            gpio_q  <= GPIO_RESET;
            timer_q <= '0;
        end else begin
            addr_q  <= addr_d;
            write_q <= write_d;
            wait_q  <= wait_d;
            gpio_q  <= gpio_d;
            timer_q <= timer_d;
        end
    end

    // RAM contents survive reset; reset only kills an in-flight write via state_q.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= HWDATA;
        end
    end

endmodule

// File: tb/tb_ahb_lite_subsys.sv
// Directed plus randomized bench for ahb_lite_subsys: two instances
// (RAM_WAIT=2 and RAM_WAIT=0) checked against a transaction-level model.
module tb_ahb_lite_subsys;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic        hready [2];
    logic        hresp  [2];
    logic [2:0]  gpio   [2];

    always #5 clk = ~clk;

    ahb_lite_subsys #(
        .RAM_DEPTH (64),
        .RAM_WAIT  (2),
        .GPIO_W    (3),
        .GPIO_RESET(3'b010)
    ) u0 (
        .clk     (clk),
        .reset   (rst),
        .HADDR   (haddr[0]),
        .HTRANS  (htrans[0]),
        .HWRITE  (hwrite[0]),
        .HWDATA  (hwdata[0]),
        .HRDATA  (hrdata[0]),
        .HREADY  (hready[0]),
        .HRESP   (hresp[0]),
        .gpio_out(gpio[0])
    );

    ahb_lite_subsys #(
        .RAM_DEPTH (64),
        .RAM_WAIT  (0),
        .GPIO_W    (3),
        .GPIO_RESET(3'b000)
    ) u1 (
        .clk     (clk),
        .reset   (rst),
        .HADDR   (haddr[1]),
        .HTRANS  (htrans[1]),
        .HWRITE  (hwrite[1]),
        .HWDATA  (hwdata[1]),
        .HRDATA  (hrdata[1]),
        .HREADY  (hready[1]),
        .HRESP   (hresp[1]),
        .gpio_out(gpio[1])
    );

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    logic [31:0] mem_m [2][64];
    bit          wf    [2][64];
    logic [2:0]  gm    [2];
    logic [2:0]  gr    [2];
    int          rw    [2];

    // Results of the last transfer.
    logic [31:0] t_rd;
    int          t_wait;
    logic        t_rdy1, t_resp1, t_resp2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        haddr[d]  = a;
        hwrite[d] = wr;
        htrans[d] = 2'b10;
        n = 0;
        while (hready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("addr_timeout", 32'(hready[d]), 32'd1);
        @(negedge clk);
        htrans[d] = 2'b00;
        hwdata[d] = wd;
        t_rdy1  = hready[d];
        t_resp1 = hresp[d];
        t_wait  = 0;
        while (hready[d] !== 1'b1 && t_wait < 50) begin
            @(negedge clk);
            t_wait++;
        end
        if (t_wait >= 50) chk("data_timeout", 32'(hready[d]), 32'd1);
        t_rd    = hrdata[d];
        t_resp2 = hresp[d];
    endtask

    // GPIO register write through the bus plus model update and pin check.
    task automatic gpio_op(input int d, input logic [1:0] off, input logic [31:0] v);
        xfer(d, 1'b1, 32'h2000_0000 + 32'(off) * 4, v);
        chk("gpio_wr_waits", 32'(t_wait), 32'd0);
        case (off)
            2'd0: gm[d] = v[2:0];
            2'd1: gm[d] = gm[d] | v[2:0];
            2'd2: gm[d] = gm[d] & ~v[2:0];
            default: gm[d] = gm[d] ^ v[2:0];
        endcase
        @(negedge clk);
        chk("gpio_out", 32'(gpio[d]), 32'(gm[d]));
    endtask

    task automatic ram_wr(input int d, input int idx, input logic [31:0] v);
        xfer(d, 1'b1, 32'(idx) * 4 + 32'($urandom_range(0, 3)), v);
        chk("ram_wr_waits", 32'(t_wait), 32'(rw[d]));
        mem_m[d][idx] = v;
        wf[d][idx] = 1'b1;
    endtask

    task automatic ram_rd(input int d, input int idx);
        xfer(d, 1'b0, 32'(idx) * 4, 32'h0);
        chk("ram_rd_waits", 32'(t_wait), 32'(rw[d]));
        chk("ram_rd_data", t_rd, mem_m[d][idx]);
    endtask

    task automatic err_xfer(input int d, input bit wr, input logic [31:0] a);
        xfer(d, wr, a, 32'hFFFF_FFFF);
        chk("err_c1_ready", 32'(t_rdy1), 32'd0);
        chk("err_c1_resp", 32'(t_resp1), 32'd1);
        chk("err_low_cycles", 32'(t_wait), 32'd1);
        chk("err_c2_resp", 32'(t_resp2), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pa [8];
        logic [31:0] pd [8];
        bit          pw [8];
        logic [31:0] v;
        int          cw, cr;

        gr[0] = 3'b010;
        gr[1] = 3'b000;
        rw[0] = 2;
        rw[1] = 0;
        for (int d = 0; d < 2; d++) begin
            haddr[d]  = '0;
            htrans[d] = 2'b00;
            hwrite[d] = 1'b0;
            hwdata[d] = '0;
            gm[d]     = gr[d];
            for (int i = 0; i < 64; i++) begin
                wf[d][i]    = 1'b0;
                mem_m[d][i] = '0;
            end
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_hready", 32'(hready[d]), 32'd1);
            chk("rst_hresp", 32'(hresp[d]), 32'd0);
            chk("rst_hrdata", hrdata[d], 32'd0);
            chk("rst_gpio", 32'(gpio[d]), 32'(gr[d]));
        end
        rst = 1'b0;

        // Wait-stated RAM write and read.
        ram_wr(0, 2, 32'hDEAD_BEEF);
        ram_rd(0, 2);

        // Reset during the first wait cycle of a RAM write.
        gpio_op(0, 2'd0, 32'h5);
        @(negedge clk);
        haddr[0]  = 32'h8;
        hwrite[0] = 1'b1;
        htrans[0] = 2'b10;
        @(negedge clk);
        htrans[0] = 2'b00;
        hwdata[0] = 32'h1234_5678;
        chk("midwr_wait", 32'(hready[0]), 32'd0);
        rst = 1'b1;
        #1;
        chk("midwr_rst_hready", 32'(hready[0]), 32'd1);
        chk("midwr_rst_gpio", 32'(gpio[0]), 32'(gr[0]));
        @(negedge clk);
        rst = 1'b0;
        gm[0] = gr[0];
        gm[1] = gr[1];
        ram_rd(0, 2);

        // GPIO data/set/clear/toggle sequence.
        gpio_op(0, 2'd0, 32'h5);
        gpio_op(0, 2'd1, 32'h2);
        gpio_op(0, 2'd2, 32'h1);
        gpio_op(0, 2'd3, 32'h7);
        xfer(0, 1'b0, 32'h2000_0000, 32'h0);
        chk("gpio_data_rd", t_rd, 32'(gm[0]));
        for (int o = 1; o < 4; o++) begin
            xfer(0, 1'b0, 32'h2000_0000 + 32'(o) * 4, 32'h0);
            chk("gpio_w_only_rd", t_rd, 32'd0);
        end

        // Unmapped accesses, including the first word past the RAM.
        err_xfer(0, 1'b0, 32'h3000_0000);
        err_xfer(0, 1'b1, 32'h3000_0000);
        err_xfer(0, 1'b1, 32'h0000_0100);
        err_xfer(0, 1'b1, 32'h2000_0014);
        @(negedge clk);
        chk("err_gpio_kept", 32'(gpio[0]), 32'(gm[0]));
        ram_rd(0, 2);
        ram_wr(0, 63, 32'hCAFE_F00D);
        ram_rd(0, 63);

        // Timer wrap and clear-on-write.
        @(negedge clk);
        force u0.timer_q = 32'hFFFF_FFFF;
        #1;
        chk("timer_wrap", u0.timer_d, 32'h0);
        release u0.timer_q;
        xfer(0, 1'b1, 32'h2000_0010, 32'h0000_0ABC);
        cw = cyc;
        repeat (3) @(negedge clk);
        xfer(0, 1'b0, 32'h2000_0010, 32'h0);
        cr = cyc;
        chk("timer_elapsed", t_rd, 32'(cr - cw - 1));

        // Pipelined zero-wait RAM traffic on the second instance.
        pa = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8, 32'h8, 32'h8};
        pw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) pd[k] = $urandom;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk("pipe_hready", 32'(hready[1]), 32'd1);
            if (k > 0 && !pw[k-1]) begin
                v = pa[k-1];
                chk("pipe_rd", hrdata[1], mem_m[1][v[7:2]]);
            end
            if (k > 0 && pw[k-1]) begin
                v = pa[k-1];
                hwdata[1] = pd[k-1];
                mem_m[1][v[7:2]] = pd[k-1];
                wf[1][v[7:2]] = 1'b1;
            end
            if (k < 8) begin
                haddr[1]  = pa[k];
                hwrite[1] = pw[k];
                htrans[1] = 2'b11;
            end else begin
                htrans[1] = 2'b00;
            end
        end

        // Randomized mix on both instances.
        for (int n = 0; n < 80; n++) begin
            int d, kind, idx;
            d    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 3));
            idx  = int'($urandom_range(0, 63));
            case (kind)
                0: ram_wr(d, idx, $urandom);
                1: begin
                    if (wf[d][idx]) ram_rd(d, idx);
                    else ram_wr(d, idx, $urandom);
                end
                2: gpio_op(d, 2'($urandom_range(0, 3)), $urandom);
                default: err_xfer(d, 1'($urandom_range(0, 1)), 32'h8000_0000 | $urandom);
            endcase
        end
        for (int d = 0; d < 2; d++) begin
            xfer(d, 1'b0, 32'h2000_0000, 32'h0);
            chk("final_gpio_rd", t_rd, 32'(gm[d]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
